fft4_seq_ctrl: RTL and testbench

- Sequencer for the 8-bit radix-2 single-path delay-feedback 4-point FFT datapath.
- Accepts a continuous sample stream in frames of 4 and drives the datapath's stage select `sel[1:0]` and twiddle operand `c`.
- Feeds zeros to drain the pipeline when input stops, and produces output valid/index tags aligned to the datapath output `y`.
- Sits between the sample source and the datapath. The datapath has no enable, so this block advances it every clock.

---
 rtl/fft4_seq_ctrl.sv | 95 +++++++++
 tb/tb_fft4_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft4_seq_ctrl.sv
// fft4_seq_ctrl: frame sequencer for the radix-2 SDF 4-point FFT datapath (stage select, twiddle, drain, output tags).
// Define FFT4_BITREV_EN to tag outputs with natural-order bin numbers instead of arrival slots.
module fft4_seq_ctrl #(
   parameter int             n   = 8,
   parameter int             LAT = 5,
   parameter logic [n-1:0]   TW0 = 8'h01,
   parameter logic [n-1:0]   TW1 = 8'hFF
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [1:0]   sel,
   output logic [n-1:0] c,
   output logic         zero_in,
   output logic         out_valid,
   output logic [1:0]   out_index,
   output logic         out_last,
   output logic         frame_err
);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [2:0]  fcnt_q, fcnt_d;
   logic        rdy_q, rdy_d;
   logic        err_q, err_d;
   logic [3:0]  pipe_q [LAT];
   logic [3:0]  pipe_d [LAT];
   logic        acc, slot_v;
   logic [3:0]  tag;
   always_comb begin
      acc     = rdy_q & in_valid;
      state_d = state_q;
      cnt_d   = cnt_q;
      fcnt_d  = fcnt_q;
      err_d   = err_q;
      slot_v  = 1'b0;
      case (state_q)
         IDLE: if (acc) begin
            state_d = RUN;
            cnt_d   = 2'd1;
            slot_v  = 1'b1;
         end
         RUN: begin
            cnt_d  = cnt_q + 2'd1;
            slot_v = acc | (cnt_q != 2'd0);
            err_d  = err_q | ((cnt_q != 2'd0) & ~in_valid);
            // an empty frame boundary ends the burst; drain LAT cycles so the last frame clears y
            if (cnt_q == 2'd0 && !in_valid) begin
               state_d = FLUSH;
               fcnt_d  = 3'(LAT - 1);
            end
         end
         FLUSH: begin
            cnt_d  = (fcnt_q == 3'd0) ? 2'd0 : cnt_q + 2'd1;
            fcnt_d = fcnt_q - 3'd1;
            if (fcnt_q == 3'd0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rdy_d     = (state_d != FLUSH);
      pipe_d[0] = {slot_v, cnt_q, cnt_q == 2'd3};
      for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
   end
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         fcnt_q  <= 3'd0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
         pipe_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fcnt_q  <= fcnt_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
         pipe_q  <= pipe_d;
      end
   end
   assign tag       = pipe_q[LAT-1];
   assign in_ready  = rdy_q;
   assign zero_in   = ~acc;
   assign sel       = cnt_q;
   assign c         = (cnt_q == 2'd1) ? TW1 : TW0;
   assign frame_err = err_q;
   assign out_valid = tag[3];
   assign out_last  = tag[3] & tag[0];
`ifdef FFT4_BITREV_EN
   assign out_index = {tag[1], tag[2]};
`else
   assign out_index = tag[2:1];
`endif
endmodule

// File: tb/tb_fft4_seq_ctrl.sv
// tb_fft4_seq_ctrl: scoreboard bench; expected output tags are queued with their due cycle as slots are driven.
module tb_fft4_seq_ctrl;
   localparam int         LAT = 5;
   localparam logic [7:0] TW0 = 8'h01;
   localparam logic [7:0] TW1 = 8'hFF;
   logic       clk = 1'b0, clear = 1'b1, in_valid = 1'b0;
   logic       in_ready, zero_in, out_valid, out_last, frame_err;
   logic [1:0] sel, out_index;
   logic [7:0] c;
   int         cyc = 0, checks = 0, failures = 0;
   logic       exp_v;
   typedef struct {int due; logic [1:0] idx; logic last;} exp_t;
   exp_t q[$];

   fft4_seq_ctrl #(.n(8), .LAT(LAT), .TW0(TW0), .TW1(TW1)) dut (
      .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .c(c),
      .zero_in(zero_in), .out_valid(out_valid), .out_index(out_index), .out_last(out_last),
      .frame_err(frame_err));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [1:0] map_idx(input logic [1:0] s);
`ifdef FFT4_BITREV_EN
      return {s[0], s[1]};
`else
      return s;
`endif
   endfunction

   task automatic push(input int s);
      q.push_back('{cyc + LAT, map_idx(2'(s)), s == 3});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      checks++;
      if (out_valid !== exp_v) begin
         failures++;
         $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_v);
      end
      if (exp_v) begin
         checks += 2;
         if (out_index !== q[0].idx) begin
            failures++;
            $display("FAIL out_index cyc=%0d got=%0d exp=%0d", cyc, out_index, q[0].idx);
         end
         if (out_last !== q[0].last) begin
            failures++;
            $display("FAIL out_last cyc=%0d got=%b exp=%b", cyc, out_last, q[0].last);
         end
         void'(q.pop_front());
      end
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
   end

   task automatic test_reset();
      #1 clear = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks += 2;
      if ({in_ready, zero_in, sel, c} !== {1'b0, 1'b1, 2'b00, TW0}) begin
         failures++;
         $display("FAIL reset_ctrl got=%b_%b_%b_%h exp=0_1_00_%h", in_ready, zero_in, sel, c, TW0);
      end
      if ({out_valid, out_index, out_last, frame_err} !== 5'b0) begin
         failures++;
         $display("FAIL reset_out got=%b_%b_%b_%b exp=0_00_0_0", out_valid, out_index, out_last, frame_err);
      end
      @(posedge clk);
      #1 clear = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL ready_before_edge got=%b exp=0", in_ready);
      end
      tick();
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_edge got=%b exp=1", in_ready);
      end
      tick();
   endtask

   task automatic test_single_frame();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         @(negedge clk);
         checks += 2;
         if ({sel, c} !== {2'(i), (i == 1) ? TW1 : TW0}) begin
            failures++;
            $display("FAIL single_sel_c slot=%0d got=%b/%h exp=%b/%h", i, sel, c, 2'(i), (i == 1) ? TW1 : TW0);
         end
         if ({in_ready, zero_in} !== 2'b10) begin
            failures++;
            $display("FAIL single_accept slot=%0d got=%b%b exp=10", i, in_ready, zero_in);
         end
         push(i);
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({in_ready, zero_in} !== 2'b11) begin
         failures++;
         $display("FAIL single_boundary got=%b%b exp=11", in_ready, zero_in);
      end
      tick();
      for (int i = 0; i < LAT; i++) begin
         @(negedge clk);
         checks++;
         if ({in_ready, zero_in} !== 2'b01) begin
            failures++;
            $display("FAIL single_flush k=%0d got=%b%b exp=01", i, in_ready, zero_in);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if ({in_ready, sel} !== 3'b100) begin
         failures++;
         $display("FAIL single_idle got=%b/%b exp=1/00", in_ready, sel);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1;
         @(negedge clk);
         checks++;
         if ({in_ready, zero_in, sel} !== {2'b10, 2'(i % 4)}) begin
            failures++;
            $display("FAIL b2b slot=%0d got=%b%b/%b exp=10/%b", i, in_ready, zero_in, sel, 2'(i % 4));
         end
         push(i % 4);
         tick();
      end
      in_valid = 1'b0;
      repeat (LAT + 2) tick();
      @(negedge clk);
      checks++;
      if ({in_ready, sel} !== 3'b100) begin
         failures++;
         $display("FAIL b2b_idle got=%b/%b exp=1/00", in_ready, sel);
      end
      tick();
   endtask

   task automatic test_flush_ignore();
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      in_valid = 1'b1;
      for (int i = 0; i < LAT; i++) begin
         @(negedge clk);
         checks++;
         if ({in_ready, zero_in} !== 2'b01) begin
            failures++;
            $display("FAIL flush_ignore k=%0d got=%b%b exp=01", i, in_ready, zero_in);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if ({in_ready, zero_in, sel} !== 4'b1000) begin
         failures++;
         $display("FAIL flush_reaccept got=%b%b/%b exp=10/00", in_ready, zero_in, sel);
      end
      for (int i = 0; i < 4; i++) begin
         push(i);
         tick();
      end
      in_valid = 1'b0;
      repeat (LAT + 2) tick();
   endtask

   task automatic test_mid_frame_gap();
      @(negedge clk);
      checks++;
      if (frame_err !== 1'b0) begin
         failures++;
         $display("FAIL gap_err_pre got=%b exp=0", frame_err);
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         in_valid = (i != 2);
         @(negedge clk);
         checks += 2;
         if (zero_in !== (i == 2)) begin
            failures++;
            $display("FAIL gap_zero slot=%0d got=%b exp=%b", i, zero_in, i == 2);
         end
         if (frame_err !== (i == 3)) begin
            failures++;
            $display("FAIL gap_err slot=%0d got=%b exp=%b", i, frame_err, i == 3);
         end
         push(i);
         tick();
      end
      in_valid = 1'b0;
      repeat (LAT + 2) tick();
      @(negedge clk);
      checks++;
      if (frame_err !== 1'b1) begin
         failures++;
         $display("FAIL gap_err_sticky got=%b exp=1", frame_err);
      end
      tick();
   endtask

   task automatic test_reset_mid_frame();
      in_valid = 1'b1;
      tick();
      #2 clear = 1'b0;
      q.delete();
      #1;
      checks++;
      if ({in_ready, zero_in, sel, c, out_valid, frame_err} !== {1'b0, 1'b1, 2'b00, TW0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL rst_mid got=%b%b/%b/%h/%b%b exp=01/00/%h/00", in_ready, zero_in, sel, c, out_valid, frame_err, TW0);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1 clear = 1'b1;
      repeat (LAT + 6) tick();
      @(negedge clk);
      checks++;
      if ({in_ready, frame_err} !== 2'b10) begin
         failures++;
         $display("FAIL rst_mid_after got=%b%b exp=10", in_ready, frame_err);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_flush_ignore();
      test_mid_frame_gap();
      test_reset_mid_frame();
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
